// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit CPU: opcodes, sequencer states, instruction layout.
package cpu_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_NOT  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_SUBI = 4'h9;
    localparam logic [3:0] OP_MOVI = 4'hA;
    localparam logic [3:0] OP_NOP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT
    } seq_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [5:0] imm6;
    } instr_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier for the sequencer.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  instr_t             instr,
    output logic               is_imm,
    output logic               writes_rd,
    output logic               is_halt,
    output logic [DATA_W-1:0]  imm
);

    always_comb begin
        is_imm    = (instr.opcode == OP_ADDI) || (instr.opcode == OP_SUBI) ||
                    (instr.opcode == OP_MOVI);
        // r0 and r7 are not writable; undefined opcodes fall out as non-writing
        writes_rd = (instr.opcode <= OP_MOVI) && (instr.rd != 3'd0) && (instr.rd != 3'd7);
        is_halt   = (instr.opcode == OP_HALT);
        imm       = DATA_W'(instr.imm6);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/writeback control unit for the 9-bit CPU.
// Optional CPU_SEQ_PERF_EN adds retired/stall performance counters.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 10,
    parameter int DATA_W  = 9
) (
    input  logic               clock,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [15:0]        imem_data,
    output logic [3:0]         alu_opcode,
    output logic               alu_b_imm,
    output logic [DATA_W-1:0]  imm,
    output logic [2:0]         rd_sel,
    output logic [2:0]         rs_sel,
    output logic               reg_we,
    output logic               halted
`ifdef CPU_SEQ_PERF_EN
    ,
    output logic [15:0]        retired_count,
    output logic [15:0]        stall_count
`endif
);

    seq_state_t         state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    instr_t             ir_q, ir_d;
    logic [3:0]         op_q, op_d;
    logic               b_imm_q, b_imm_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [2:0]         rd_q, rd_d, rs_q, rs_d;
    logic               wr_q, wr_d;

    logic               dec_is_imm, dec_writes, dec_halt;
    logic [DATA_W-1:0]  dec_imm;
    logic               capture;

    instr_decode #(.DATA_W(DATA_W)) u_dec (
        .instr     (ir_q),
        .is_imm    (dec_is_imm),
        .writes_rd (dec_writes),
        .is_halt   (dec_halt),
        .imm       (dec_imm)
    );

    assign capture = (state_q == FETCH) && imem_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = FETCH;
            FETCH:     if (capture) state_d = DECODE;
            DECODE:    state_d = EXECUTE;
            EXECUTE:   state_d = dec_halt ? HALT : WRITEBACK;
            WRITEBACK: state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state_q == FETCH);
        reg_we   = (state_q == WRITEBACK) && wr_q;
        halted   = (state_q == HALT);
    end

    // ALU controls are only reloaded on the DECODE edge, holding through EXECUTE/WRITEBACK
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        op_d    = op_q;
        b_imm_d = b_imm_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        wr_d    = wr_q;
        if (capture) begin
            ir_d = instr_t'(imem_data);
            pc_d = pc_q + 1'b1;
        end
        if (state_q == DECODE) begin
            op_d    = ir_q.opcode;
            b_imm_d = dec_is_imm;
            imm_d   = dec_imm;
            rd_d    = ir_q.rd;
            rs_d    = ir_q.rs;
            wr_d    = dec_writes;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            ir_q    <= '0;
            op_q    <= OP_NOP;
            b_imm_q <= 1'b0;
            imm_q   <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_q    <= op_d;
            b_imm_q <= b_imm_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            wr_q    <= wr_d;
        end
    end

    assign imem_addr  = pc_q;
    assign alu_opcode = op_q;
    assign alu_b_imm  = b_imm_q;
    assign imm        = imm_q;
    assign rd_sel     = rd_q;
    assign rs_sel     = rs_q;

`ifdef CPU_SEQ_PERF_EN
    logic [15:0] retired_q, retired_d, stall_q, stall_d;
    logic        retire;

    assign retire = (state_q == WRITEBACK) || ((state_q == EXECUTE) && dec_halt);

    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (retire && (retired_q != 16'hFFFF))
            retired_d = retired_q + 16'd1;
        if ((state_q == FETCH) && !imem_valid && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level reference model with random stalls.
module tb_cpu_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [3:0]  alu_opcode;
    logic        alu_b_imm;
    logic [8:0]  imm;
    logic [2:0]  rd_sel, rs_sel;
    logic        reg_we, halted;
`ifdef CPU_SEQ_PERF_EN
    logic [15:0] retired_count, stall_count;
`endif

    int tests = 0;
    int fails = 0;

    // reference model state
    int         pc_m;
    logic [3:0] prev_op;
    int         retired_m, stall_m;

    cpu_sequencer #(.IMEM_AW(10), .DATA_W(9)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_b_imm  (alu_b_imm),
        .imm        (imm),
        .rd_sel     (rd_sel),
        .rs_sel     (rs_sel),
        .reg_we     (reg_we),
        .halted     (halted)
`ifdef CPU_SEQ_PERF_EN
        ,
        .retired_count (retired_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        pc_m      = 0;
        prev_op   = 4'hB;
        retired_m = 0;
        stall_m   = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"},  imem_addr, 0);
        check({tag, "_req"},   imem_req, 0);
        check({tag, "_we"},    reg_we, 0);
        check({tag, "_halt"},  halted, 0);
        check({tag, "_op"},    alu_opcode, 4'hB);
        check({tag, "_bimm"},  alu_b_imm, 0);
        check({tag, "_imm"},   imm, 0);
        check({tag, "_rd"},    rd_sel, 0);
        check({tag, "_rs"},    rs_sel, 0);
`ifdef CPU_SEQ_PERF_EN
        check({tag, "_ret"},   retired_count, 0);
        check({tag, "_stall"}, stall_count, 0);
`endif
    endtask

    // Entered #1 after the edge that put the sequencer in FETCH; returns likewise
    // (or in HALT for opcode F).
    task automatic run_instr(input logic [15:0] ins, input int stalls);
        logic [3:0] op;
        logic [2:0] rd, rs;
        logic       exp_we, exp_bimm;
        op       = ins[15:12];
        rd       = ins[11:9];
        rs       = ins[8:6];
        exp_bimm = (op >= 4'd8) && (op <= 4'd10);
        exp_we   = (op <= 4'd10) && (rd >= 3'd1) && (rd <= 3'd6);
        for (int s = 0; s < stalls; s++) begin
            imem_valid = 1'b0;
            imem_data  = 16'($urandom);
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, pc_m);
            step();
            stall_m++;
        end
        imem_valid = 1'b1;
        imem_data  = ins;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, pc_m);
        step();
        pc_m = (pc_m + 1) % 1024;
        imem_valid = 1'($urandom_range(0, 1));
        imem_data  = 16'($urandom);
        check("dec_req", imem_req, 0);
        check("dec_addr", imem_addr, pc_m);
        check("dec_op_hold", alu_opcode, prev_op);
        check("dec_we", reg_we, 0);
        step();
        check("ex_op", alu_opcode, op);
        check("ex_rd", rd_sel, rd);
        check("ex_rs", rs_sel, rs);
        check("ex_imm", imm, {3'b000, ins[5:0]});
        check("ex_bimm", alu_b_imm, exp_bimm);
        check("ex_req", imem_req, 0);
        check("ex_we", reg_we, 0);
        prev_op = op;
        step();
        if (op == 4'hF) begin
            retired_m++;
            check("halt_flag", halted, 1);
            check("halt_req", imem_req, 0);
            check("halt_we", reg_we, 0);
        end else begin
            check("wb_we", reg_we, exp_we);
            check("wb_req", imem_req, 0);
            check("wb_halt", halted, 0);
            check("wb_op_hold", alu_opcode, op);
            step();
            retired_m++;
            imem_valid = 1'b0;
        end
`ifdef CPU_SEQ_PERF_EN
        check("perf_retired", retired_count, retired_m);
        check("perf_stall", stall_count, stall_m);
`endif
    endtask

    initial begin
        int p0;
        logic [15:0] r;
        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_data  = 16'h0;
        model_reset();
        #3;
        check_reset_vals("rst");
        step();
        step();
        reset = 1'b0;
        check("idle_req", imem_req, 0);
        step();

        // ADD r1,r2 then MOVI r3,#45
        run_instr(16'h3280, 0);
        check("add_addr", imem_addr, 1);
        run_instr(16'hA62D, 0);
        // 5 stalled FETCH cycles
        run_instr(16'h1A40, 5);
        // rd=0 write suppressed, NOP never writes
        p0 = pc_m;
        run_instr(16'h3080, 0);
        run_instr(16'hB000, 0);
        check("pc_adv2", imem_addr, p0 + 2);

        // random non-halting instructions with random stalls
        for (int i = 0; i < 40; i++) begin
            r = 16'($urandom);
            r[15:12] = 4'($urandom_range(0, 14));
            run_instr(r, int'($urandom_range(0, 3)));
        end

        // walk the PC to 1023, wrap, then HALT
        while (pc_m != 1023) run_instr(16'hB000, 0);
        run_instr(16'hB000, 0);
        check("wrap_addr", imem_addr, 0);
        run_instr(16'hF000, 0);
        for (int i = 0; i < 20; i++) begin
            imem_valid = 1'b1;
            imem_data  = 16'h3280;
            step();
            check("halted_hold", halted, 1);
            check("halted_req", imem_req, 0);
            check("halted_we", reg_we, 0);
        end
        check("halted_addr", imem_addr, pc_m);

        // reset during EXECUTE
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem_valid = 1'b0;
        model_reset();
        step();
        imem_valid = 1'b1;
        imem_data  = 16'h3280;
        step();
        imem_valid = 1'b0;
        step();
        check("pre_rst_op", alu_opcode, 3);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rel_req", imem_req, 0);
        step();
        run_instr(16'h3280, 0);
        check("restart_addr", imem_addr, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
